// File: rtl/nand_gate_unit_pkg.sv
// Shared constants for the NAND glue-logic unit.
`default_nettype none

package nand_gate_unit_pkg;

  localparam int WIDTH_MAX = 64;

endpackage

`default_nettype wire

// File: rtl/nand_gate_unit.sv
// Bitwise NAND with combinational result, enable-gated registered copy
// and a saturating count of captures that changed the registered value.
`default_nettype none

module nand_gate_unit
  import nand_gate_unit_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             en,
  input  logic             clr_cnt,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             y_q_vld,
  output logic             all_zero,
  output logic [CNT_W-1:0] toggle_cnt
);

  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_width_check
    $error("nand_gate_unit: WIDTH out of range");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_nand_bit
    assign y[i] = ~(a[i] & b[i]);
  end

  assign all_zero = ~|y;

  logic [WIDTH-1:0] r_y_q;
  logic             r_vld;
  logic [CNT_W-1:0] r_cnt;
  logic             w_toggle;

  // The very first capture after reset has nothing valid to compare against.
  assign w_toggle = en && r_vld && (y != r_y_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y_q <= '1;
      r_vld <= 1'b0;
      r_cnt <= '0;
    end else begin
      if (en) begin
        r_y_q <= y;
        r_vld <= 1'b1;
      end
      if (clr_cnt) begin
        r_cnt <= '0;
      end else if (w_toggle && (r_cnt != c_cnt_max)) begin
        r_cnt <= r_cnt + c_cnt_one;
      end
    end
  end

  assign y_q        = r_y_q;
  assign y_q_vld    = r_vld;
  assign toggle_cnt = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_nand_gate_unit.sv
// Self-checking bench: vector table for the combinational core, scoreboard for the registered path.
`default_nettype none

module tb_nand_gate_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main 1-bit instance
  logic a1 = 1'b0, b1 = 1'b0, en1 = 1'b0, clr1 = 1'b0;
  logic y1, yq1, vld1, az1;
  logic [15:0] cnt1;

  nand_gate_unit #(.WIDTH(1), .CNT_W(16)) u_main (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .en(en1), .clr_cnt(clr1),
    .y(y1), .y_q(yq1), .y_q_vld(vld1), .all_zero(az1), .toggle_cnt(cnt1)
  );

  // 8-bit instance
  logic [7:0] a8 = '0, b8 = '0;
  logic en8 = 1'b0, clr8 = 1'b0;
  logic [7:0] y8, yq8;
  logic vld8, az8;
  logic [15:0] cnt8;

  nand_gate_unit #(.WIDTH(8), .CNT_W(16)) u_wide (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .en(en8), .clr_cnt(clr8),
    .y(y8), .y_q(yq8), .y_q_vld(vld8), .all_zero(az8), .toggle_cnt(cnt8)
  );

  // Narrow-counter instance for saturation
  logic as = 1'b0, bs = 1'b0, ens = 1'b0, clrs = 1'b0;
  logic ys, yqs, vlds, azs;
  logic [1:0] cnts;

  nand_gate_unit #(.WIDTH(1), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .a(as), .b(bs), .en(ens), .clr_cnt(clrs),
    .y(ys), .y_q(yqs), .y_q_vld(vlds), .all_zero(azs), .toggle_cnt(cnts)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
    logic       az;
    bit         wide;
  } vec_t;

  typedef struct packed {
    logic        yq;
    logic        vld;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  logic        m_yq  = 1'b1;
  logic        m_vld = 1'b0;
  logic [15:0] m_cnt = '0;

  // Drive one edge on the main instance; model predicts the post-edge state.
  task automatic step(input logic a, input logic b, input logic en, input logic clr);
    logic ny;
    logic tog;
    exp_t e;
    exp_t got;
    a1 = a; b1 = b; en1 = en; clr1 = clr;
    ny  = ~(a & b);
    tog = en && m_vld && (ny != m_yq);
    if (en) begin
      m_yq  = ny;
      m_vld = 1'b1;
    end
    if (clr) m_cnt = '0;
    else if (tog && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    e.yq = m_yq; e.vld = m_vld; e.cnt = m_cnt;
    sb.push_back(e);
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      total_cnt++;
      $display("FAIL scoreboard: queue empty, got 0 entries required 1");
    end else begin
      got = sb.pop_front();
      check("sb_y_q", yq1, got.yq);
      check("sb_vld", vld1, got.vld);
      check("sb_cnt", cnt1, got.cnt);
    end
    en1 = 1'b0; clr1 = 1'b0;
  endtask

  task automatic sat_step(input logic a, input logic b);
    as = a; bs = b; ens = 1'b1;
    @(posedge clk); #1;
    ens = 1'b0;
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{8'h00, 8'h00, 8'h01, 1'b0, 1'b0};
    vecs[1] = '{8'h01, 8'h00, 8'h01, 1'b0, 1'b0};
    vecs[2] = '{8'h00, 8'h01, 8'h01, 1'b0, 1'b0};
    vecs[3] = '{8'h01, 8'h01, 8'h00, 1'b1, 1'b0};
    vecs[4] = '{8'hF0, 8'hCC, 8'h3F, 1'b0, 1'b1};
    vecs[5] = '{8'hFF, 8'hFF, 8'h00, 1'b1, 1'b1};
    vecs[6] = '{8'hAA, 8'h55, 8'hFF, 1'b0, 1'b1};
    vecs[7] = '{8'h00, 8'hFF, 8'hFF, 1'b0, 1'b1};

    // Reset phase
    repeat (2) @(posedge clk);
    #1;
    check("rst_y_q", yq1, 64'h1);
    check("rst_vld", vld1, 64'h0);
    check("rst_cnt", cnt1, 64'h0);
    check("rst_wide_y_q", yq8, 64'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Combinational truth table, 5 ns per vector
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].wide) begin
        a8 = vecs[i].a; b8 = vecs[i].b;
        #5;
        check($sformatf("vec%0d_y8", i), y8, vecs[i].y);
        check($sformatf("vec%0d_az8", i), az8, vecs[i].az);
      end else begin
        a1 = vecs[i].a[0]; b1 = vecs[i].b[0];
        #5;
        check($sformatf("vec%0d_y1", i), y1, vecs[i].y);
        check($sformatf("vec%0d_az1", i), az1, vecs[i].az);
      end
    end
    check("hold_y_q_en0", yq1, 64'h1);
    @(posedge clk); #1;

    // Registered path: first capture, then hold with en=0
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("cap_y_q", yq1, 64'h0);
    check("cap_vld", vld1, 64'h1);
    check("first_cap_no_toggle", cnt1, 64'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("en0_hold", yq1, 64'h0);

    // Ten alternating captures
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) step(1'b0, 1'b0, 1'b1, 1'b0);
      else            step(1'b1, 1'b1, 1'b1, 1'b0);
    end
    check("toggle10", cnt1, 64'd10);

    // Clear wins over a simultaneous toggle
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check("clr_priority", cnt1, 64'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("pre_reset_cnt", cnt1, 64'd3);

    // Saturation with a 2-bit counter
    sat_step(1'b1, 1'b1);
    check("sat_first", cnts, 64'd0);
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) sat_step(1'b0, 1'b0);
      else            sat_step(1'b1, 1'b1);
      if (i == 2) check("sat_reach3", cnts, 64'd3);
    end
    check("sat_hold3", cnts, 64'd3);

    // Asynchronous reset mid-run, checked between edges
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_y_q", yq1, 64'h1);
    check("async_rst_vld", vld1, 64'h0);
    check("async_rst_cnt", cnt1, 64'h0);
    check("async_rst_sat_cnt", cnts, 64'h0);
    a1 = 1'b1; b1 = 1'b1;
    #1;
    check("y_tracks_in_reset", y1, 64'h0);
    a1 = 1'b0;
    #1;
    check("y_tracks_in_reset2", y1, 64'h1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
